// File: rtl/oam_dma.sv
// OAM DMA engine: a write of page XX to the trigger register copies LEN bytes from XX00.. to
// DST_BASE.., one byte per BYTE_PERIOD clocks, with busy held so the arbiter stalls the CPU.
module oam_dma #(
  parameter int unsigned LEN         = 160,
  parameter int unsigned BYTE_PERIOD = 4,
  parameter logic [15:0] DST_BASE    = 16'hFE00,
  parameter logic [15:0] REG_ADDR    = 16'hFF46,
  localparam int unsigned AW         = 16,
  localparam int unsigned DW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wen,
  input  logic [AW-1:0] cpu_w_addr,
  input  logic [DW-1:0] cpu_w_data,
  output logic [DW-1:0] reg_rdata,
  output logic [AW-1:0] mem_r_addr,
  input  logic [DW-1:0] mem_r_data,
  output logic          mem_wen,
  output logic [AW-1:0] mem_w_addr,
  output logic [DW-1:0] mem_w_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned PH_W  = $clog2(BYTE_PERIOD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTE_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    page_q, page_d;
  logic [DW-1:0]    byte_q, byte_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             done_d;
  logic             busy_d;
  logic             mem_wen_d;
  logic [AW-1:0]    mem_r_addr_d;
  logic [AW-1:0]    mem_w_addr_d;
  logic [DW-1:0]    mem_w_data_d;
  logic             trigger_c;

  assign trigger_c = cpu_wen && (cpu_w_addr == REG_ADDR);
  assign reg_rdata = page_q;

  // State register; outputs are registered from the next-state decode so they align with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      page_q     <= '0;
      byte_q     <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mem_wen    <= 1'b0;
      mem_r_addr <= '0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      done       <= done_d;
      busy       <= busy_d;
      mem_wen    <= mem_wen_d;
      mem_r_addr <= mem_r_addr_d;
      mem_w_addr <= mem_w_addr_d;
      mem_w_data <= mem_w_data_d;
    end
  end

  // Next state: a trigger restarts from byte 0 and pre-empts completion on the same edge
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_c) begin
          state_d = XFER;
          page_d  = cpu_w_data;
          idx_d   = '0;
          phase_d = '0;
        end
      end
      XFER: begin
        if (trigger_c) begin
          page_d  = cpu_w_data;
          idx_d   = '0;
          phase_d = '0;
        end else begin
          if (phase_q == '0) begin
            byte_d = mem_r_data;
          end
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next state only; write happens in the last phase of each byte
  always_comb begin
    busy_d       = 1'b0;
    mem_wen_d    = 1'b0;
    mem_r_addr_d = '0;
    mem_w_addr_d = '0;
    mem_w_data_d = '0;
    if (state_d == XFER) begin
      busy_d       = 1'b1;
      mem_r_addr_d = {page_d, {DW{1'b0}}} + AW'(idx_d);
      if (phase_d == PH_LAST) begin
        mem_wen_d    = 1'b1;
        mem_w_addr_d = DST_BASE + AW'(idx_d);
        mem_w_data_d = byte_d;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: scenario table plus random scenarios against a transfer-level model,
// and hand-written sequences for reset mid-transfer and the LEN=1 / BYTE_PERIOD=2 variant.
module tb_oam_dma;

  localparam int LEN = 160;
  localparam int BP  = 4;
  localparam logic [15:0] DST = 16'hFE00;
  localparam logic [15:0] REG = 16'hFF46;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_wen;
  logic [15:0] cpu_w_addr;
  logic [7:0]  cpu_w_data;
  logic [7:0]  reg_rdata;
  logic [15:0] mem_r_addr;
  logic [7:0]  mem_r_data;
  logic        mem_wen;
  logic [15:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        busy;
  logic        done;

  logic        cpu_wen6;
  logic [15:0] cpu_w_addr6;
  logic [7:0]  cpu_w_data6;
  logic [7:0]  reg_rdata6;
  logic [15:0] mem_r_addr6;
  logic [7:0]  mem_r_data6;
  logic        mem_wen6;
  logic [15:0] mem_w_addr6;
  logic [7:0]  mem_w_data6;
  logic        busy6;
  logic        done6;

  logic [7:0] src [65536];
  logic [7:0] oam [256];

  assign mem_r_data  = src[mem_r_addr];
  assign mem_r_data6 = src[mem_r_addr6];

  oam_dma u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_wen(cpu_wen), .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data),
    .reg_rdata(reg_rdata), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .mem_wen(mem_wen),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .busy(busy), .done(done)
  );

  oam_dma #(.LEN(1), .BYTE_PERIOD(2)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .cpu_wen(cpu_wen6), .cpu_w_addr(cpu_w_addr6),
    .cpu_w_data(cpu_w_data6), .reg_rdata(reg_rdata6), .mem_r_addr(mem_r_addr6),
    .mem_r_data(mem_r_data6), .mem_wen(mem_wen6), .mem_w_addr(mem_w_addr6),
    .mem_w_data(mem_w_data6), .busy(busy6), .done(done6)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wrec_t;

  typedef struct {
    logic [7:0] p1;
    bit         rt;
    int         dly;
    logic [7:0] p2;
    int         xw;
    int         xd;
    string      nm;
  } scn_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_busy;
    logic [7:0]  exp_rdata;
  } dec_t;

  wrec_t wlog[$];
  wrec_t exp_w[$];
  int    dlog[$];
  logic  dbusy[$];
  int    exp_d[$];
  int    cyc = 0;
  int    n_tot = 0;
  int    n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Destination memory: the DUT writes land here
  always @(posedge clk) begin
    if (mem_wen && mem_w_addr[15:8] == DST[15:8]) oam[mem_w_addr[7:0]] <= mem_w_data;
  end

  always @(negedge clk) begin : mon
    wrec_t r;
    if (mem_wen) begin
      r.cyc  = cyc;
      r.addr = mem_w_addr;
      r.data = mem_w_data;
      wlog.push_back(r);
    end
    if (done) begin
      dlog.push_back(cyc);
      dbusy.push_back(busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Caller must be at a negedge; the following posedge is the trigger edge
  task automatic trigger(input logic [7:0] p, output int t);
    cpu_wen    = 1'b1;
    cpu_w_addr = REG;
    cpu_w_data = p;
    @(negedge clk);
    cpu_wen    = 1'b0;
    cpu_w_addr = 16'h0000;
    cpu_w_data = 8'h00;
    t = cyc;
  endtask

  // One transfer started at edge t; cut short by a trigger at edge stop (stop < 0: runs to end)
  task automatic add_xfer(input int t, input logic [7:0] p, input int stop);
    wrec_t r;
    for (int k = 0; k < LEN; k++) begin
      r.cyc = t + k * BP + BP - 1;
      if (stop >= 0 && r.cyc >= stop) break;
      r.addr = DST + 16'(k);
      r.data = src[{p, 8'h00} + 16'(k)];
      exp_w.push_back(r);
    end
    if (stop < 0 || t + LEN * BP < stop) exp_d.push_back(t + LEN * BP);
  endtask

  task automatic model(input int t1, input logic [7:0] p1, input bit rt, input int t2,
                       input logic [7:0] p2);
    exp_w.delete();
    exp_d.delete();
    add_xfer(t1, p1, rt ? t2 : -1);
    if (rt) add_xfer(t2, p2, -1);
  endtask

  task automatic run_scn(input scn_t s);
    int w0, d0, t1, t2, tlast, nw, nd, mism, fi;
    logic [7:0] plast;
    w0 = wlog.size();
    d0 = dlog.size();
    @(negedge clk);
    trigger(s.p1, t1);
    chk({s.nm, "/busy_rise"}, int'(busy), 1);
    chk({s.nm, "/rdata"}, int'(reg_rdata), int'(s.p1));
    chk({s.nm, "/r_addr0"}, int'(mem_r_addr), int'({s.p1, 8'h00}));
    t2 = 0;
    tlast = t1;
    plast = s.p1;
    if (s.rt) begin
      while (cyc < t1 + s.dly - 1) @(negedge clk);
      trigger(s.p2, t2);
      chk({s.nm, "/busy_retrig"}, int'(busy), 1);
      tlast = t2;
      plast = s.p2;
    end
    while (cyc < tlast + LEN * BP + 4) @(negedge clk);
    model(t1, s.p1, s.rt, t2, s.p2);
    nw = wlog.size() - w0;
    chk({s.nm, "/n_writes"}, nw, exp_w.size());
    if (s.xw >= 0) chk({s.nm, "/n_writes_tbl"}, nw, s.xw);
    mism = 0;
    fi = -1;
    for (int i = 0; i < exp_w.size() && i < nw; i++) begin
      if (wlog[w0+i].cyc != exp_w[i].cyc || wlog[w0+i].addr != exp_w[i].addr ||
          wlog[w0+i].data != exp_w[i].data) begin
        mism++;
        if (fi < 0) fi = i;
      end
    end
    n_tot++;
    if (mism == 0) n_pass++;
    else $display("FAIL %s/write_seq: %0d bad, first #%0d got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                  s.nm, mism, fi, wlog[w0+fi].cyc - t1, wlog[w0+fi].addr, wlog[w0+fi].data,
                  exp_w[fi].cyc - t1, exp_w[fi].addr, exp_w[fi].data);
    nd = dlog.size() - d0;
    chk({s.nm, "/n_done"}, nd, exp_d.size());
    if (s.xd >= 0) chk({s.nm, "/n_done_tbl"}, nd, s.xd);
    if (nd == exp_d.size() && nd > 0) begin
      chk({s.nm, "/done_latency"}, dlog[d0] - tlast, exp_d[0] - tlast);
      chk({s.nm, "/busy_at_done"}, int'(dbusy[d0]), 0);
    end
    mism = 0;
    for (int i = 0; i < LEN; i++) if (oam[i] != src[{plast, 8'h00} + 16'(i)]) mism++;
    chk({s.nm, "/oam_contents"}, mism, 0);
    chk({s.nm, "/busy_end"}, int'(busy), 0);
  endtask

  initial begin
    scn_t tbl[6];
    dec_t dec[5];
    scn_t s;
    int w0, d0, t1;

    tbl[0] = '{p1: 8'hC0, rt: 1'b0, dly: 0,   p2: 8'h00, xw: 160, xd: 1, nm: "basic"};
    tbl[1] = '{p1: 8'hC0, rt: 1'b1, dly: 200, p2: 8'hD0, xw: 210, xd: 1, nm: "retrig_b50"};
    tbl[2] = '{p1: 8'hC0, rt: 1'b1, dly: 640, p2: 8'hA5, xw: 320, xd: 1, nm: "retrig_final"};
    tbl[3] = '{p1: 8'h3A, rt: 1'b1, dly: 7,   p2: 8'h5B, xw: 161, xd: 1, nm: "retrig_mid"};
    tbl[4] = '{p1: 8'h00, rt: 1'b0, dly: 0,   p2: 8'h00, xw: 160, xd: 1, nm: "page0"};
    tbl[5] = '{p1: 8'h77, rt: 1'b1, dly: 1,   p2: 8'hFF, xw: 160, xd: 1, nm: "retrig_next"};
    dec[0] = '{addr: 16'hFF45, data: 8'hC0, exp_busy: 1'b0, exp_rdata: 8'h00};
    dec[1] = '{addr: 16'hFF47, data: 8'hC0, exp_busy: 1'b0, exp_rdata: 8'h00};
    dec[2] = '{addr: 16'h7F46, data: 8'h12, exp_busy: 1'b0, exp_rdata: 8'h00};
    dec[3] = '{addr: 16'hFF06, data: 8'h34, exp_busy: 1'b0, exp_rdata: 8'h00};
    dec[4] = '{addr: 16'hEF46, data: 8'h56, exp_busy: 1'b0, exp_rdata: 8'h00};

    for (int i = 0; i < 65536; i++) src[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) src[16'hC000 + 16'(i)] = 8'(i);

    rst_n = 1'b0;
    cpu_wen = 1'b0; cpu_w_addr = 16'h0000; cpu_w_data = 8'h00;
    cpu_wen6 = 1'b0; cpu_w_addr6 = 16'h0000; cpu_w_data6 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/mem_wen", int'(mem_wen), 0);
    chk("rst/r_addr", int'(mem_r_addr), 0);
    chk("rst/w_addr", int'(mem_w_addr), 0);
    chk("rst/w_data", int'(mem_w_data), 0);
    chk("rst/rdata", int'(reg_rdata), 0);
    rst_n = 1'b1;

    // Writes to neighbouring addresses must not start a transfer or touch the page register
    w0 = wlog.size();
    foreach (dec[i]) begin
      @(negedge clk);
      cpu_wen = 1'b1; cpu_w_addr = dec[i].addr; cpu_w_data = dec[i].data;
      @(negedge clk);
      cpu_wen = 1'b0;
      chk($sformatf("decode_%h/busy", dec[i].addr), int'(busy), int'(dec[i].exp_busy));
      chk($sformatf("decode_%h/rdata", dec[i].addr), int'(reg_rdata), int'(dec[i].exp_rdata));
    end
    repeat (8) @(negedge clk);
    chk("decode/no_writes", wlog.size() - w0, 0);

    foreach (tbl[i]) run_scn(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      s.p1  = 8'($urandom_range(0, 255));
      s.rt  = 1'($urandom_range(0, 1));
      s.dly = $urandom_range(1, 640);
      s.p2  = 8'($urandom_range(0, 255));
      s.xw  = -1;
      s.xd  = -1;
      s.nm  = $sformatf("rand%0d", i);
      run_scn(s);
    end

    // Reset during the write phase of byte 80
    @(negedge clk);
    d0 = dlog.size();
    trigger(8'hC0, t1);
    while (cyc < t1 + 80 * BP + 3) @(negedge clk);
    chk("midrst/pre_wen", int'(mem_wen), 1);
    chk("midrst/pre_w_addr", int'(mem_w_addr), int'(DST + 16'd80));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/mem_wen", int'(mem_wen), 0);
    chk("midrst/busy", int'(busy), 0);
    chk("midrst/rdata", int'(reg_rdata), 0);
    chk("midrst/r_addr", int'(mem_r_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wlog.size();
    repeat (700) @(negedge clk);
    chk("midrst/no_writes_after", wlog.size() - w0, 0);
    chk("midrst/no_done", dlog.size() - d0, 0);
    chk("midrst/busy_after", int'(busy), 0);

    // LEN=1, BYTE_PERIOD=2 variant
    @(negedge clk);
    cpu_wen6 = 1'b1; cpu_w_addr6 = REG; cpu_w_data6 = 8'h12;
    @(negedge clk);
    cpu_wen6 = 1'b0;
    chk("len1/c0_busy", int'(busy6), 1);
    chk("len1/c0_wen", int'(mem_wen6), 0);
    chk("len1/c0_r_addr", int'(mem_r_addr6), int'(16'h1200));
    chk("len1/c0_rdata", int'(reg_rdata6), int'(8'h12));
    @(negedge clk);
    chk("len1/c1_wen", int'(mem_wen6), 1);
    chk("len1/c1_w_addr", int'(mem_w_addr6), int'(DST));
    chk("len1/c1_w_data", int'(mem_w_data6), int'(src[16'h1200]));
    chk("len1/c1_done", int'(done6), 0);
    @(negedge clk);
    chk("len1/c2_done", int'(done6), 1);
    chk("len1/c2_busy", int'(busy6), 0);
    chk("len1/c2_wen", int'(mem_wen6), 0);
    @(negedge clk);
    chk("len1/c3_done", int'(done6), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
